// File: rtl/neuron_weight_sequencer.sv
// ---------------------------------------------------------------------------
// neuron_weight_sequencer
// Walks one neuron's weight ROM (1-cycle read latency, bias stored after the
// weights), pairs each incoming activation with its weight and closes the
// evaluation with a bias beat towards the neuron MAC.
//
// Ports:
//   clk_i, reset_i          clock (rising edge), async active-low reset
//   start_i                 begin one evaluation (ignored unless idle)
//   busy_o, done_o          evaluation in progress / bias beat accepted pulse
//   act_valid_i/_data_i     activation stream in, act_ready_o handshake
//   rom_addr_o, rom_data_i  ROM address (next-address, combinational) / data
//   valid_o, ready_i        output beat handshake
//   act_o, weight_o, last_o output beat payload (last_o marks the bias beat)
//
// Optional feature macro WEIGHT_LOAD_EN adds a ROM write port usable in idle:
//   load_valid_i, load_addr_i, load_data_i -> rom_wen_o, rom_wdata_o
// ---------------------------------------------------------------------------
module neuron_weight_sequencer #(
   parameter int unsigned ADDR_WIDTH  = 3,
   parameter int unsigned WORD_SIZE   = 8,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned NUM_WEIGHTS = 7
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   input  logic                  act_valid_i,
   input  logic [DATA_WIDTH-1:0] act_data_i,
   output logic                  act_ready_o,
   output logic [ADDR_WIDTH-1:0] rom_addr_o,
   input  logic [WORD_SIZE-1:0]  rom_data_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] act_o,
   output logic [WORD_SIZE-1:0]  weight_o,
   output logic                  last_o
`ifdef WEIGHT_LOAD_EN
   ,
   input  logic                  load_valid_i,
   input  logic [ADDR_WIDTH-1:0] load_addr_i,
   input  logic [WORD_SIZE-1:0]  load_data_i,
   output logic                  rom_wen_o,
   output logic [WORD_SIZE-1:0]  rom_wdata_o
`endif
);

   localparam logic [ADDR_WIDTH-1:0] LAST_W_ADDR = ADDR_WIDTH'(NUM_WEIGHTS - 1);

   // Weights plus bias must fit in the ROM address space.
   if ((NUM_WEIGHTS + 1) > (1 << ADDR_WIDTH)) begin : g_cfg_check
      $error("neuron_weight_sequencer: NUM_WEIGHTS+1 exceeds 2**ADDR_WIDTH");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME,
      S_RUN,
      S_BIAS,
      S_DRAIN
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    valid_q, valid_d;
   logic [DATA_WIDTH-1:0]   act_q, act_d;
   logic [WORD_SIZE-1:0]    weight_q, weight_d;
   logic                    last_q, last_d;
   logic                    done_q, done_d;
   logic                    out_free_c;
   logic                    act_ready_c;
   logic                    load_c;

`ifdef WEIGHT_LOAD_EN
   // ROM writes are only honoured while idle; they also mask start_i.
   assign load_c      = (state_q == S_IDLE) && load_valid_i;
   assign rom_wen_o   = load_c;
   assign rom_wdata_o = load_data_i;
`else
   assign load_c      = 1'b0;
`endif

   assign out_free_c = !valid_q || ready_i;

   // Next-state, address and output-beat computation
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      valid_d     = valid_q;
      act_d       = act_q;
      weight_d    = weight_q;
      last_d      = last_q;
      done_d      = 1'b0;
      act_ready_c = 1'b0;

      // A transferring beat frees the register unless reloaded below.
      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            addr_d = '0;
            if (start_i && !load_c) begin
               state_d = S_PRIME;
            end
         end
         S_PRIME: begin
            // ROM data for address 0 lands during this cycle.
            state_d = S_RUN;
         end
         S_RUN: begin
            act_ready_c = out_free_c;
            if (act_valid_i && out_free_c) begin
               act_d    = act_data_i;
               weight_d = rom_data_i;
               last_d   = 1'b0;
               valid_d  = 1'b1;
               addr_d   = addr_q + ADDR_WIDTH'(1);
               if (addr_q == LAST_W_ADDR) begin
                  state_d = S_BIAS;
               end
            end
         end
         S_BIAS: begin
            // addr_q now points at the bias word.
            if (out_free_c) begin
               act_d    = '0;
               weight_d = rom_data_i;
               last_d   = 1'b1;
               valid_d  = 1'b1;
               state_d  = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (ready_i) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               done_d  = 1'b1;
               addr_d  = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            addr_d  = '0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         valid_q  <= 1'b0;
         act_q    <= '0;
         weight_q <= '0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         valid_q  <= valid_d;
         act_q    <= act_d;
         weight_q <= weight_d;
         last_q   <= last_d;
         done_q   <= done_d;
      end
   end

   // Presenting the next address keeps rom_data_i aligned with addr_q.
   always_comb begin
      rom_addr_o = addr_d;
`ifdef WEIGHT_LOAD_EN
      if (load_c) begin
         rom_addr_o = load_addr_i;
      end
`endif
   end

   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = done_q;
   assign act_ready_o = act_ready_c;
   assign valid_o     = valid_q;
   assign act_o       = act_q;
   assign weight_o    = weight_q;
   assign last_o      = last_q;

endmodule
